// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//   N-channel debouncer for push-buttons and slide switches. Each channel has a
//   2-flop synchroniser, a four-state settle FSM whose counter advances only on
//   the slow sample strobe, and a stable level. On top of the level it produces
//   registered rise/fall pulses, an optional press-toggle state and optional
//   hold-to-repeat pulses.
//
// Ports
//   clk      in   1       system clock, all state on posedge
//   rst      in   1       synchronous active-high reset
//   tick     in   1       sample strobe; settle/repeat counters advance only when 1
//   raw_in   in   NUM_CH  asynchronous raw inputs
//   clr_tgl  in   NUM_CH  per-channel synchronous clear of tgl (wins over a rise)
//   level    out  NUM_CH  debounced stable level
//   rise     out  NUM_CH  one-clk pulse on level 0->1
//   fall     out  NUM_CH  one-clk pulse on level 1->0
//   tgl      out  NUM_CH  flips on every rise for channels set in TOGGLE_MASK
//   rpt      out  NUM_CH  one-clk auto-repeat pulse every REPEAT_TICKS ticks held
// -----------------------------------------------------------------------------
module multi_debouncer #(
  parameter int unsigned        NUM_CH       = 4,
  parameter int unsigned        CNT_W        = 12,
  parameter int unsigned        STABLE_CNT   = 4095,
  parameter logic [NUM_CH-1:0]  TOGGLE_MASK  = NUM_CH'(4'b0010),
  parameter int unsigned        REPEAT_TICKS = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [NUM_CH-1:0] clr_tgl,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] tgl,
  output logic [NUM_CH-1:0] rpt
);

  localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

  if (64'(STABLE_CNT) < 64'd1 || 64'(STABLE_CNT) >= CNT_LIM) begin : g_bad_stable
    $error("multi_debouncer: STABLE_CNT must be in 1..2**CNT_W-1");
  end
  if (64'(REPEAT_TICKS) >= CNT_LIM) begin : g_bad_repeat
    $error("multi_debouncer: REPEAT_TICKS must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST =
    (REPEAT_TICKS > 0) ? CNT_W'(REPEAT_TICKS - 1) : '0;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } state_e;

  // Synchroniser runs every clock; only the settle counting is tick-gated.
  logic [NUM_CH-1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             rpt_q, rpt_d;
    logic             tgl_q, tgl_d;

    // Settle FSM: a pending level only completes after STABLE_CNT ticks; any
    // sample of the old level (tick or not) throws the progress away.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
        ST_LO: begin
          if (s2_q[i]) begin
            state_d = PEND_HI;
            cnt_d   = '0;
          end
        end
        PEND_HI: begin
          if (!s2_q[i]) begin
            state_d = ST_LO;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == STABLE_LAST) begin
              state_d = ST_HI;
              rise_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HI: begin
          if (!s2_q[i]) begin
            state_d = PEND_LO;
            cnt_d   = '0;
          end
        end
        PEND_LO: begin
          if (s2_q[i]) begin
            state_d = ST_HI;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == STABLE_LAST) begin
              state_d = ST_LO;
              fall_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_LO;
          cnt_d   = '0;
        end
      endcase
    end

    // Repeat cadence runs while the level is high, including a bouncy release
    // (PEND_LO), so a short bounce does not restart the repeat timing.
    always_comb begin
      rcnt_d = rcnt_q;
      rpt_d  = 1'b0;
      if (REPEAT_TICKS == 0 || state_q == ST_LO || state_q == PEND_HI) begin
        rcnt_d = '0;
      end else if (tick) begin
        if (rcnt_q == REPEAT_LAST) begin
          rpt_d  = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
    end

    // Clear has priority over a rise landing on the same edge.
    always_comb begin
      tgl_d = 1'b0;
      if (TOGGLE_MASK[i] && !clr_tgl[i]) begin
        tgl_d = tgl_q ^ rise_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_LO;
        cnt_q   <= '0;
        rcnt_q  <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        rpt_q   <= 1'b0;
        tgl_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rcnt_q  <= rcnt_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        rpt_q   <= rpt_d;
        tgl_q   <= tgl_d;
      end
    end

    assign level[i] = (state_q == ST_HI) || (state_q == PEND_LO);
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign rpt[i]   = rpt_q;
    assign tgl[i]   = tgl_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
//   Directed bench for multi_debouncer (4 channels, STABLE_CNT=4,
//   REPEAT_TICKS=3, toggle on channel 1). A behavioural model tracks, per
//   channel, the delayed raw value, how many ticks a differing value has
//   persisted and how many ticks the level has been held; every cycle the DUT
//   outputs are compared against it. Hand-computed literal checks pin the
//   timing of the model itself.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;
  localparam int         NUM_CH = 4;
  localparam int         S      = 4;
  localparam int         R      = 3;
  localparam logic [3:0] MASK   = 4'b0010;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic [3:0] raw_in, clr_tgl;
  logic [3:0] level, rise, fall, tgl, rpt;

  int nerr = 0;
  int nchk = 0;
  bit cmp_en = 1'b0;
  bit slow = 1'b0;
  int cyc = 0;

  multi_debouncer #(
    .NUM_CH(NUM_CH), .CNT_W(12), .STABLE_CNT(S),
    .TOGGLE_MASK(MASK), .REPEAT_TICKS(R)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .raw_in(raw_in), .clr_tgl(clr_tgl),
    .level(level), .rise(rise), .fall(fall), .tgl(tgl), .rpt(rpt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [3:0] m_d1, m_d2, m_lvl, m_pend, m_rise, m_fall, m_rpt, m_tgl;
  int         m_n  [NUM_CH];
  int         m_tk [NUM_CH];
  logic       m_was_hi;

  always @(posedge clk) begin
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pend = '0;
      m_rise = '0; m_fall = '0; m_rpt = '0; m_tgl = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_n[c] = 0;
        m_tk[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_was_hi  = m_lvl[c];
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        m_rpt[c]  = 1'b0;
        if (m_d2[c] == m_lvl[c]) begin
          m_pend[c] = 1'b0;
        end else if (!m_pend[c]) begin
          m_pend[c] = 1'b1;
          m_n[c]    = 0;
        end else if (tick) begin
          m_n[c] = m_n[c] + 1;
          if (m_n[c] == S) begin
            m_lvl[c]  = m_d2[c];
            m_rise[c] = m_d2[c];
            m_fall[c] = !m_d2[c];
            m_pend[c] = 1'b0;
          end
        end
        if (m_rise[c]) begin
          m_tk[c] = 0;
        end else if (m_was_hi && tick) begin
          m_tk[c] = m_tk[c] + 1;
          if (m_tk[c] % R == 0) m_rpt[c] = 1'b1;
        end
        if (clr_tgl[c]) m_tgl[c] = 1'b0;
        else if (MASK[c] && m_rise[c]) m_tgl[c] = !m_tgl[c];
      end
      m_d2 = m_d1;
      m_d1 = raw_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_level", level, m_lvl);
      chk("model_rise",  rise,  m_rise);
      chk("model_fall",  fall,  m_fall);
      chk("model_tgl",   tgl,   m_tgl);
      chk("model_rpt",   rpt,   m_rpt);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      tick = slow ? (cyc % 8 == 0) : 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b1; raw_in = 4'b0; clr_tgl = 4'b0;
    step(3);
    cmp_en = 1'b1;
    chk("rst_level", level, 4'b0000);
    chk("rst_rise",  rise,  4'b0000);
    chk("rst_fall",  fall,  4'b0000);
    chk("rst_tgl",   tgl,   4'b0000);
    chk("rst_rpt",   rpt,   4'b0000);
    rst = 1'b0;
    step(2);

    // Clean press and release on channel 0
    raw_in[0] = 1'b1;
    step(6);
    chk("t1_pre_rise",  rise,  4'b0000);
    chk("t1_pre_level", level, 4'b0000);
    step(1);
    chk("t1_rise",  rise,  4'b0001);
    chk("t1_level", level, 4'b0001);
    chk("t1_tgl0",  tgl,   4'b0000);
    step(1);
    chk("t1_rise_once", rise, 4'b0000);
    raw_in[0] = 1'b0;
    step(6);
    chk("t1_pre_fall", fall,  4'b0000);
    chk("t1_hold_lvl", level, 4'b0001);
    step(1);
    chk("t1_fall",      fall,  4'b0001);
    chk("t1_level_low", level, 4'b0000);
    step(4);

    // Bounce on channel 2: high 3, low 1, then held high
    raw_in[2] = 1'b1;
    step(3);
    raw_in[2] = 1'b0;
    step(1);
    raw_in[2] = 1'b1;
    step(6);
    chk("t2_no_early_rise", rise, 4'b0000);
    step(1);
    chk("t2_rise", rise, 4'b0100);
    raw_in[2] = 1'b0;
    step(10);

    // Toggle on channel 1
    raw_in[1] = 1'b1;
    step(7);
    chk("t3_rise_a", rise, 4'b0010);
    chk("t3_tgl_a",  tgl,  4'b0010);
    raw_in[1] = 1'b0;
    step(10);
    chk("t3_tgl_kept", tgl, 4'b0010);
    raw_in[1] = 1'b1;
    step(7);
    chk("t3_rise_b", rise, 4'b0010);
    chk("t3_tgl_b",  tgl,  4'b0000);
    raw_in[1] = 1'b0;
    step(10);
    raw_in[1] = 1'b1;
    step(6);
    clr_tgl[1] = 1'b1;
    step(1);
    chk("t3_rise_c",     rise, 4'b0010);
    chk("t3_clr_wins",   tgl,  4'b0000);
    clr_tgl[1] = 1'b0;
    step(1);
    chk("t3_tgl_after",  tgl,  4'b0000);
    raw_in[1] = 1'b0;
    step(10);

    // Hold-to-repeat on channel 3
    raw_in[3] = 1'b1;
    step(7);
    chk("t4_rise", rise, 4'b1000);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("t4_rpt", rpt, (k % 3 == 0) ? 4'b1000 : 4'b0000);
    end
    raw_in[3] = 1'b0;
    step(7);
    chk("t4_fall", fall, 4'b1000);
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("t4_no_rpt", rpt, 4'b0000);
    end

    // Slow tick on channel 0: tick on every 8th clock
    slow = 1'b1;
    while (cyc % 8 != 1) step(1);
    raw_in[0] = 1'b1;
    step(31);
    chk("t5_pre_level", level, 4'b0000);
    step(1);
    chk("t5_level", level, 4'b0001);
    chk("t5_rise",  rise,  4'b0001);
    raw_in[0] = 1'b0;
    step(48);
    chk("t5_released", level, 4'b0000);
    while (cyc % 8 != 1) step(1);
    raw_in[0] = 1'b1;
    step(10);
    raw_in[0] = 1'b0;
    step(1);
    raw_in[0] = 1'b1;
    step(28);
    chk("t5_glitch_pre", level, 4'b0000);
    step(1);
    chk("t5_glitch_level", level, 4'b0001);
    chk("t5_glitch_rise",  rise,  4'b0001);
    raw_in[0] = 1'b0;
    step(48);
    slow = 1'b0;
    step(2);

    // Reset mid-settle with other state live
    raw_in[1] = 1'b1;
    step(7);
    chk("t6_tgl_set", tgl, 4'b0010);
    raw_in[1] = 1'b0;
    step(10);
    raw_in[3] = 1'b1;
    step(8);
    chk("t6_ch3_high", level, 4'b1000);
    raw_in[0] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    chk("t6_rst_level", level, 4'b0000);
    chk("t6_rst_rise",  rise,  4'b0000);
    chk("t6_rst_fall",  fall,  4'b0000);
    chk("t6_rst_tgl",   tgl,   4'b0000);
    chk("t6_rst_rpt",   rpt,   4'b0000);
    rst = 1'b0;
    step(6);
    chk("t6_pre_rise", rise, 4'b0000);
    step(1);
    chk("t6_rise", rise, 4'b1001);
    raw_in = 4'b0000;
    step(10);

    // All channels together
    raw_in = 4'b1111;
    step(7);
    chk("t6_all_rise", rise, 4'b1111);
    chk("t6_all_tgl",  tgl,  4'b0010);
    raw_in = 4'b0000;
    step(7);
    chk("t6_all_fall", fall, 4'b1111);
    step(4);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
